// File: rtl/awb_pkg.sv
// Shared constants for the gray-world white-balance block: gain format and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package awb_pkg;

    localparam int GAIN_W    = 12;
    localparam int GAIN_FRAC = 8;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 12'h100;
    localparam logic [GAIN_W-1:0] GAIN_MAX   = 12'hFFF;

    // Statistics / gain-update FSM
    localparam logic [1:0] ST_ACCUM = 2'd0;  // collecting sums, waiting for frame end
    localparam logic [1:0] ST_DIV_R = 2'd1;  // dividing G sum by R sum
    localparam logic [1:0] ST_DIV_B = 2'd2;  // dividing G sum by B sum
    localparam logic [1:0] ST_PEND  = 2'd3;  // results ready, waiting for next frame start

endpackage

// File: rtl/awb_gain_if.sv
// Pixel stream bundle: raster syncs plus 8-bit RGB, input and output side.
// Latency: n/a (wiring only).
// Backpressure: none; the stream is free-running, timing is set by the source.
interface awb_gain_if;

    logic       in_vsync;
    logic       in_hsync;
    logic       in_den;
    logic [7:0] in_data_R;
    logic [7:0] in_data_G;
    logic [7:0] in_data_B;

    logic       out_vsync;
    logic       out_hsync;
    logic       out_den;
    logic [7:0] out_data_R;
    logic [7:0] out_data_G;
    logic [7:0] out_data_B;

    // master: the video source / sink around the block
    modport master (
        output in_vsync, in_hsync, in_den, in_data_R, in_data_G, in_data_B,
        input  out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B
    );

    // slave: the white-balance block itself
    modport slave (
        input  in_vsync, in_hsync, in_den, in_data_R, in_data_G, in_data_B,
        output out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B
    );

endinterface

// File: rtl/awb_divider.sv
// Serial restoring unsigned divider, one quotient bit per clock, zero-divisor and clamp handling.
// Latency: done pulses NUM_W+1 clocks after start; quotient is valid while done is high.
// Backpressure: none; start is ignored while running, abort drops the operation immediately.
// Ports: start/abort control, numerator/denominator operands, done pulse, quotient (Q_W bits).
module awb_divider #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 12,
    parameter int Q_W   = 12,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [Q_W-1:0] Q_UNITY = Q_W'(1) << FRAC;

    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] dvs;
    logic [NUM_W-1:0] quo;      // shifts out numerator bits, shifts in quotient bits
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [DEN_W:0]   shifted;
    logic [DEN_W-1:0] trial;
    logic             ge;

    always_comb begin
        shifted = {rem, quo[NUM_W-1]};
        ge      = shifted >= {1'b0, dvs};
        // Only used when ge is set, in which case the difference is below dvs and fits DEN_W bits.
        trial   = shifted[DEN_W-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                run <= 1'b0;
            end else if (start) begin
                rem <= '0;
                dvs <= denominator;
                quo <= numerator;
                cnt <= CNT_W'(NUM_W);
                run <= 1'b1;
            end else if (run) begin
                rem <= ge ? trial : shifted[DEN_W-1:0];
                quo <= {quo[NUM_W-2:0], ge};
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // A zero divisor leaves the channel at unity; anything above the gain range saturates.
    always_comb begin
        if (dvs == '0)
            quotient = Q_UNITY;
        else if (|quo[NUM_W-1:Q_W])
            quotient = '1;
        else
            quotient = quo[Q_W-1:0];
    end

endmodule

// File: rtl/awb_gain.sv
// Gray-world auto white balance: per-frame RGB sums -> R/B gains (G/R, G/B) applied on the next frame.
// Latency: 2 clocks from in_* to out_*; gains update only at a vsync rising edge.
// Backpressure: none; a too-short vertical blank abandons the gain update and keeps old gains.
// Ports: clk, reset_n, awb_en (0 = unity gains), vid (pixel stream in/out), gain_r/gain_b status, busy.
module awb_gain #(
    parameter int source_h  = 512,
    parameter int source_v  = 512,
    parameter int GAIN_W    = awb_pkg::GAIN_W,
    parameter int GAIN_FRAC = awb_pkg::GAIN_FRAC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              awb_en,
    awb_gain_if.slave         vid,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              busy
);
    import awb_pkg::*;

    localparam int SUM_W  = $clog2(source_h * source_v) + 8;
    localparam int NUM_W  = SUM_W + GAIN_FRAC;
    localparam int PROD_W = GAIN_W + 8;
    localparam logic [GAIN_W-1:0] G_UNITY = GAIN_W'(1) << GAIN_FRAC;

    logic              vs_d;
    logic              vs_rise;
    logic              frame_end;
    logic [1:0]        state;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic [NUM_W-1:0]  num_reg;
    logic [SUM_W-1:0]  den_b_reg;
    logic [NUM_W-1:0]  div_num;
    logic [SUM_W-1:0]  div_den;
    logic              div_start, div_abort, div_done;
    logic [GAIN_W-1:0] div_q, q_r, q_b;
    logic [GAIN_W-1:0] g_eff_r, g_eff_b;
    logic              s1_vs, s1_hs, s1_den;
    logic [PROD_W-1:0] p_r, p_b;
    logic [7:0]        s1_g;

    function automatic logic [7:0] scale_sat(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] s;
        s = p >> GAIN_FRAC;
        return (|s[PROD_W-1:8]) ? 8'hFF : s[7:0];
    endfunction

    assign vs_rise   = vid.in_vsync & ~vs_d;
    assign frame_end = vs_d & ~vid.in_vsync;
    assign busy      = (state == ST_DIV_R) || (state == ST_DIV_B);

    // R division starts straight from the live sums on the frame-end cycle; B reuses the snapshot.
    assign div_num   = (state == ST_ACCUM) ? {sum_g, {GAIN_FRAC{1'b0}}} : num_reg;
    assign div_den   = (state == ST_ACCUM) ? sum_r : den_b_reg;
    assign div_start = ((state == ST_ACCUM) && frame_end) ||
                       ((state == ST_DIV_R) && div_done && !vs_rise);
    assign div_abort = busy && vs_rise;

    awb_divider #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W),
        .Q_W   (GAIN_W),
        .FRAC  (GAIN_FRAC)
    ) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (div_start),
        .abort       (div_abort),
        .numerator   (div_num),
        .denominator (div_den),
        .done        (div_done),
        .quotient    (div_q)
    );

    // Frame statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_d      <= 1'b0;
            sum_r     <= '0;
            sum_g     <= '0;
            sum_b     <= '0;
            num_reg   <= '0;
            den_b_reg <= '0;
        end else begin
            vs_d <= vid.in_vsync;
            if (frame_end) begin
                num_reg   <= {sum_g, {GAIN_FRAC{1'b0}}};
                den_b_reg <= sum_b;
                sum_r     <= '0;
                sum_g     <= '0;
                sum_b     <= '0;
            end else if (vid.in_vsync && vid.in_den) begin
                sum_r <= sum_r + SUM_W'(vid.in_data_R);
                sum_g <= sum_g + SUM_W'(vid.in_data_G);
                sum_b <= sum_b + SUM_W'(vid.in_data_B);
            end
        end
    end

    // Gain computation sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_ACCUM;
            q_r    <= G_UNITY;
            q_b    <= G_UNITY;
            gain_r <= G_UNITY;
            gain_b <= G_UNITY;
        end else begin
            case (state)
                ST_ACCUM: if (frame_end) state <= ST_DIV_R;
                ST_DIV_R: begin
                    if (vs_rise) begin
                        state <= ST_ACCUM;
                    end else if (div_done) begin
                        q_r   <= div_q;
                        state <= ST_DIV_B;
                    end
                end
                ST_DIV_B: begin
                    if (vs_rise) begin
                        state <= ST_ACCUM;
                    end else if (div_done) begin
                        q_b   <= div_q;
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (vs_rise) begin
                        gain_r <= q_r;
                        gain_b <= q_b;
                        state  <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // Pixel datapath: multiply, then shift/saturate
    assign g_eff_r = awb_en ? gain_r : G_UNITY;
    assign g_eff_b = awb_en ? gain_b : G_UNITY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vs          <= 1'b0;
            s1_hs          <= 1'b0;
            s1_den         <= 1'b0;
            p_r            <= '0;
            p_b            <= '0;
            s1_g           <= '0;
            vid.out_vsync  <= 1'b0;
            vid.out_hsync  <= 1'b0;
            vid.out_den    <= 1'b0;
            vid.out_data_R <= '0;
            vid.out_data_G <= '0;
            vid.out_data_B <= '0;
        end else begin
            s1_vs  <= vid.in_vsync;
            s1_hs  <= vid.in_hsync;
            s1_den <= vid.in_den;
            p_r    <= PROD_W'(vid.in_data_R) * PROD_W'(g_eff_r);
            p_b    <= PROD_W'(vid.in_data_B) * PROD_W'(g_eff_b);
            s1_g   <= vid.in_data_G;

            vid.out_vsync  <= s1_vs;
            vid.out_hsync  <= s1_hs;
            vid.out_den    <= s1_den;
            vid.out_data_R <= s1_den ? scale_sat(p_r) : 8'd0;
            vid.out_data_G <= s1_den ? s1_g : 8'd0;
            vid.out_data_B <= s1_den ? scale_sat(p_b) : 8'd0;
        end
    end

endmodule

// File: tb/tb_awb_gain.sv
// Bench for awb_gain on a 4x4 raster: directed gain scenarios plus random frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_awb_gain;

    localparam int BLANK_MIN = 2 * (12 + 8) + 4;   // SUM_W=12 for a 4x4 frame, GAIN_FRAC=8

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        awb_en = 1'b0;
    logic [11:0] gain_r, gain_b;
    logic        busy;

    awb_gain_if vif();

    awb_gain #(.source_h(4), .source_v(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .awb_en  (awb_en),
        .vid     (vif),
        .gain_r  (gain_r),
        .gain_b  (gain_b),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct { int vs; int hs; int de; int r; int g; int b; } px_t;
    px_t st1, exp_o;
    int  m_gr, m_gb, sr, sg, sb, pq_r, pq_b, since_fe, er, eb;
    bit  pend, prev_vs, chk_on;

    function automatic int calc_gain(input int num, input int den);
        int q;
        if (den == 0) return 256;
        q = (num * 256) / den;
        return (q > 4095) ? 4095 : q;
    endfunction

    function automatic int scale(input int px, input int g);
        int v;
        v = (px * g) / 256;
        return (v > 255) ? 255 : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st1 = '{default:0};
            exp_o = '{default:0};
            m_gr = 256; m_gb = 256;
            sr = 0; sg = 0; sb = 0;
            pend = 0; prev_vs = 0; since_fe = 0;
        end else begin
            er = awb_en ? m_gr : 256;
            eb = awb_en ? m_gb : 256;
            exp_o  = st1;
            st1.vs = int'(vif.in_vsync);
            st1.hs = int'(vif.in_hsync);
            st1.de = int'(vif.in_den);
            st1.r  = vif.in_den ? scale(int'(vif.in_data_R), er) : 0;
            st1.g  = vif.in_den ? int'(vif.in_data_G) : 0;
            st1.b  = vif.in_den ? scale(int'(vif.in_data_B), eb) : 0;
            if (vif.in_vsync && vif.in_den) begin
                sr += int'(vif.in_data_R);
                sg += int'(vif.in_data_G);
                sb += int'(vif.in_data_B);
            end
            since_fe++;
            if (prev_vs && !vif.in_vsync) begin
                pq_r = calc_gain(sg, sr);
                pq_b = calc_gain(sg, sb);
                sr = 0; sg = 0; sb = 0;
                pend = 1; since_fe = 0;
            end
            if (!prev_vs && vif.in_vsync) begin
                if (pend && since_fe >= BLANK_MIN) begin
                    m_gr = pq_r;
                    m_gb = pq_b;
                end
                pend = 0;
            end
            prev_vs = vif.in_vsync;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_vsync", int'(vif.out_vsync), exp_o.vs);
            chk("out_hsync", int'(vif.out_hsync), exp_o.hs);
            chk("out_den", int'(vif.out_den), exp_o.de);
            chk("out_data_R", int'(vif.out_data_R), exp_o.r);
            chk("out_data_G", int'(vif.out_data_G), exp_o.g);
            chk("out_data_B", int'(vif.out_data_B), exp_o.b);
            chk("gain_r", int'(gain_r), m_gr);
            chk("gain_b", int'(gain_b), m_gb);
        end
    end

    // ---------------- edge-lag and last-pixel monitor ----------------
    int   cyc = 0;
    int   e_vs, e_hs, e_de, lag_vs, lag_hs, lag_de;
    int   lo_r, lo_g, lo_b;
    logic l_in_vs = 0, l_in_hs = 0, l_in_de = 0, l_o_vs = 0, l_o_hs = 0, l_o_de = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (vif.in_vsync != l_in_vs) e_vs = cyc;
        if (vif.in_hsync != l_in_hs) e_hs = cyc;
        if (vif.in_den   != l_in_de) e_de = cyc;
        if (vif.out_vsync != l_o_vs) lag_vs = cyc - e_vs;
        if (vif.out_hsync != l_o_hs) lag_hs = cyc - e_hs;
        if (vif.out_den   != l_o_de) lag_de = cyc - e_de;
        l_in_vs = vif.in_vsync; l_in_hs = vif.in_hsync; l_in_de = vif.in_den;
        l_o_vs  = vif.out_vsync; l_o_hs = vif.out_hsync; l_o_de = vif.out_den;
        if (vif.out_den) begin
            lo_r = int'(vif.out_data_R);
            lo_g = int'(vif.out_data_G);
            lo_b = int'(vif.out_data_B);
        end
    end

    // ---------------- stimulus ----------------
    int last_r, last_g, last_b;
    bit busy_seen;

    task automatic drive(input bit vs, input bit hs, input bit de, input int r, input int g, input int b);
        @(posedge clk);
        #1;
        vif.in_vsync  = vs;
        vif.in_hsync  = hs;
        vif.in_den    = de;
        vif.in_data_R = 8'(r);
        vif.in_data_G = 8'(g);
        vif.in_data_B = 8'(b);
    endtask

    // One 4x4 frame; blanking data is non-zero to prove the den gating. egr < 0 skips the gain checks.
    task automatic drive_frame(input int r, input int g, input int b, input bit rnd,
                               input int blank, input int egr, input int egb);
        int pr, pg, pb;
        drive(1, 0, 0, 170, 170, 170);
        drive(1, 0, 0, 170, 170, 170);
        if (egr >= 0) begin
            chk("gain_r at frame start", int'(gain_r), egr);
            chk("gain_b at frame start", int'(gain_b), egb);
            chk("busy at frame start", int'(busy), 0);
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                pr = rnd ? int'($urandom_range(0, 255)) : r;
                pg = rnd ? int'($urandom_range(0, 255)) : g;
                pb = rnd ? int'($urandom_range(0, 255)) : b;
                drive(1, 1, 1, pr, pg, pb);
                last_r = pr; last_g = pg; last_b = pb;
            end
            drive(1, 0, 0, 170, 170, 170);
        end
        busy_seen = 0;
        drive(0, 0, 0, 85, 85, 85);
        for (int i = 1; i < blank; i++) begin
            drive(0, 0, 0, 85, 85, 85);
            if (busy) busy_seen = 1;
        end
    endtask

    initial begin
        vif.in_vsync = 0; vif.in_hsync = 0; vif.in_den = 0;
        vif.in_data_R = 0; vif.in_data_G = 0; vif.in_data_B = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        chk("reset out_den", int'(vif.out_den), 0);
        chk("reset out_data_R", int'(vif.out_data_R), 0);
        chk("reset gain_r", int'(gain_r), 'h100);
        chk("reset gain_b", int'(gain_b), 'h100);
        chk("reset busy", int'(busy), 0);
        reset_n = 1;
        awb_en  = 1;

        drive_frame(64, 128, 32, 0, 200, 'h100, 'h100);      // first frame at unity
        chk("first frame R unity", lo_r, 64);
        drive_frame(64, 128, 32, 0, 200, 'h200, 'h400);      // ratio gains applied
        chk("balanced R", lo_r, 128);
        chk("balanced G", lo_g, 128);
        chk("balanced B", lo_b, 128);
        drive_frame(200, 128, 32, 0, 200, 'h200, 'h400);     // R saturates
        chk("saturated R", lo_r, 255);
        chk("unscaled G", lo_g, 128);
        drive_frame(0, 128, 32, 0, 200, 163, 'h400);         // zero R sum
        drive_frame(1, 255, 32, 0, 200, 'h100, 'h400);       // huge ratio -> clamp
        drive_frame(64, 128, 32, 0, 10, 'hFFF, 2040);        // too-short blanking
        chk("busy during short blank", int'(busy_seen), 1);
        drive_frame(64, 128, 32, 0, 200, 'hFFF, 2040);       // abort kept old gains
        awb_en = 0;
        drive_frame(0, 0, 0, 1, 200, 'h200, 'h400);          // bypass, random pixels
        chk("bypass R", lo_r, last_r);
        chk("bypass G", lo_g, last_g);
        chk("bypass B", lo_b, last_b);
        chk("vsync lag", lag_vs, 2);
        chk("hsync lag", lag_hs, 2);
        chk("den lag", lag_de, 2);

        awb_en = 1;
        drive_frame(64, 128, 32, 0, 8, -1, -1);              // reset lands mid-divide
        chk("busy before reset", int'(busy), 1);
        reset_n = 0;
        #1;
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset gain_r", int'(gain_r), 'h100);
        chk("mid reset gain_b", int'(gain_b), 'h100);
        chk("mid reset out_vsync", int'(vif.out_vsync), 0);
        chk("mid reset out_data_G", int'(vif.out_data_G), 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        reset_n = 1;
        drive_frame(64, 128, 32, 0, 200, 'h100, 'h100);
        chk("post reset R unity", lo_r, 64);
        chk("post reset B unity", lo_b, 32);

        for (int f = 0; f < 10; f++) begin
            awb_en = 1'($urandom_range(0, 1));
            drive_frame(0, 0, 0, 1, ($urandom_range(0, 1) != 0) ? 200 : 10, -1, -1);
        end
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/awb_gain.md
Name: awb_gain

Overview:
- Gray-world auto-white-balance stage placed directly downstream of the CFA demosaic stage.
- Consumes its RGB stream (vsync/hsync/den plus 8-bit R, G, B).
- Accumulates per-channel sums over each frame, computes R and B gains during vertical blanking with a serial divider, and applies them to the following frame.
- G passes through unscaled. Output timing is identical to the input, delayed by 2 clocks.

Parameters:
- source_h, 512, active pixels per line.
- source_v, 512, active lines per frame.
- GAIN_W, 12, gain width (unsigned Q4.8).
- GAIN_FRAC, 8, fractional bits of gain; unity gain = 1<<GAIN_FRAC = 12'h100.
- SUM_W, clog2(source_h*source_v)+8, per-channel accumulator width (derived localparam).

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- awb_en  in  1  1 = apply computed gains; 0 = bypass (unity gains applied, statistics still run)
- in_vsync  in  1  high during the active frame
- in_hsync  in  1  high during the active line
- in_den  in  1  pixel valid
- in_data_R / in_data_G / in_data_B  in  8 each  input pixel
- out_vsync / out_hsync / out_den  out  1 each  in_* delayed 2 clocks
- out_data_R / out_data_G / out_data_B  out  8 each  balanced pixel
- gain_r / gain_b  out  GAIN_W each  gains currently applied (status)
- busy  out  1  divider running

Behaviour:
- Reset (async, active-low):
  - All out_* = 0, busy = 0.
  - gain_r = gain_b = 12'h100.
  - Accumulators cleared. FSM in ACCUM.
- Statistics:
  - On each clock with in_vsync & in_den, sum_r/g/b += in_data_*.
  - No wrap is possible at SUM_W.
- Frame end (registered vsync falling edge):
  - Snapshot the sums into num/den registers.
  - Clear the accumulators in the same cycle.
  - FSM ACCUM -> DIV_R.
- FSM states:
  - ACCUM: idle, waiting for frame end.
  - DIV_R: computes q_r = (sum_g<<GAIN_FRAC)/sum_r with a restoring divider at 1 quotient bit per clock; takes SUM_W+GAIN_FRAC cycles. Then -> DIV_B.
  - DIV_B: computes q_b = (sum_g<<GAIN_FRAC)/sum_b the same way. Then -> PEND.
  - PEND: holds the results. On vsync rising edge, loads gain_r/gain_b and returns to ACCUM.
- Gain rules:
  - Denominator 0 -> result 12'h100.
  - Quotient > 12'hFFF -> clamp to 12'hFFF.
  - Gains change only at a vsync rising edge, never mid-frame.
- Abort: a vsync rising edge while in DIV_R or DIV_B abandons the division, leaves gains unchanged and returns to ACCUM. That frame's pixels are still accumulated.
- busy = 1 in DIV_R and DIV_B only.
- Datapath (2-stage pipeline):
  - Stage 1: p_r = R*g_eff_r, p_b = B*g_eff_b (20-bit), with g_eff = awb_en ? gain : 12'h100. G is registered unchanged.
  - Stage 2: out = p>>GAIN_FRAC, saturated to 255.
  - When the stage-1 den is 0, out_data_* = 0.
- Sync signals: delayed by exactly 2 registers, matching the data.
- Blanking requirement: vertical blanking must be at least 2*(SUM_W+GAIN_FRAC)+4 clocks for gains to update. Shorter blanking triggers the abort rule.
- First frame after reset is output at unity gain.

Decomposition:
- Shared package awb_pkg:
  - GAIN_W, GAIN_FRAC, GAIN_UNITY = 12'h100, GAIN_MAX = 12'hFFF.
  - FSM state encoding: ACCUM, DIV_R, DIV_B, PEND.
- Sub-module awb_divider: serial restoring unsigned divider.
  - Signals: start, numerator, denominator, done, quotient. Handles zero-denominator and clamp.
  - Instantiated once and reused sequentially for R and B.

Test Plan:
- Ratio gains (source_h=4, source_v=4, 4x4 frame R=64 G=128 B=32, blanking 200 clocks): after the next vsync rise gain_r=12'h200, gain_b=12'h400. Second frame with the same input outputs R=G=B=128.
- Saturation (same gains, R=200): out_data_R=255, out_data_G unchanged.
- Zero denominator and clamp:
  - Frame with R=0: gain_r=12'h100.
  - Frame with R=1, G=255: gain_r=12'hFFF.
- Abort: vsync rises 10 clocks after falling -> busy drops, gain_r/gain_b keep their prior values.
- Bypass and latency: awb_en=0 with gains 12'h200 -> output equals input. out_vsync/hsync/den edges lag the input edges by exactly 2 clocks.
- Reset mid-divide: reset_n asserted while busy -> all outputs 0 immediately, gains 12'h100; next frame is passed at unity.
